// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its sharing wrapper.
//   XLEN_DEFAULT      default operand/result width
//   ALU_*             4-bit ALU control codes
//   is_legal_op(ctrl) 1 when ctrl is one of the defined opcodes
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  function automatic logic is_legal_op(input logic [3:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL,
      ALU_SLT, ALU_XOR, ALU_SRL, ALU_SLTU, ALU_SRA: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU.
//   a, b    operands
//   ctrl    ALU control code (see alu_pkg)
//   result  operation result ('0 for undefined codes)
//   z, n    result zero / result sign
//   c, v    carry-out (no-borrow for SUB) / signed overflow; 0 except ADD/SUB
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] result,
  output logic            z,
  output logic            n,
  output logic            c,
  output logic            v
);

  localparam int SHW = $clog2(XLEN);

  logic            w_sub;
  logic [XLEN-1:0] w_bx;
  logic [XLEN:0]   w_sum;
  logic [SHW-1:0]  w_shamt;

  // SUB reuses the adder as a + ~b + 1
  assign w_sub   = (ctrl == ALU_SUB);
  assign w_bx    = w_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_bx} + {{XLEN{1'b0}}, w_sub};
  assign w_shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (ctrl)
      ALU_ADD, ALU_SUB: begin
        result = w_sum[XLEN-1:0];
        c      = w_sum[XLEN];
        v      = (a[XLEN-1] == w_bx[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $signed(a) >>> w_shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign z = (result == '0);
  assign n = result[XLEN-1];

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
//   valid0/1    request lines
//   last_grant  0 = requester 0 was granted last, 1 = requester 1
//   grant0/1    one-hot (or zero) grant
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // Under contention the requester that was not granted last wins.
  assign grant0 = valid0 & (~valid1 | last_grant);
  assign grant1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between two requesters.
//   clk, rst                    clock, async active-high reset
//   req{0,1}_valid/ready        request handshake per requester
//   req{0,1}_a/b/ctrl           operands and ALU control code
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that issued the response
//   rsp_result, rsp_z/n/c/v     ALU result and flags
//   rsp_err                     ctrl was not a defined opcode
// Pipeline: grant -> operand stage -> ALU -> response stage. Both stages
// advance together whenever the response stage is empty or being consumed.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_ctrl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_ctrl,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_z,
  output logic            rsp_n,
  output logic            rsp_c,
  output logic            rsp_v,
  output logic            rsp_err
);

  logic            w_grant0, w_grant1, w_advance;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_z, w_alu_n, w_alu_c, w_alu_v;

  logic            r_last_grant;
  logic            r_op_valid, r_op_id;
  logic [XLEN-1:0] r_op_a, r_op_b;
  logic [3:0]      r_op_ctrl;

  logic            r_rsp_valid, r_rsp_id, r_rsp_err;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_z, r_rsp_n, r_rsp_c, r_rsp_v;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (r_last_grant),
    .grant0     (w_grant0),
    .grant1     (w_grant1)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a      (r_op_a),
    .b      (r_op_b),
    .ctrl   (r_op_ctrl),
    .result (w_alu_result),
    .z      (w_alu_z),
    .n      (w_alu_n),
    .c      (w_alu_c),
    .v      (w_alu_v)
  );

  // Depends only on registered state and rsp_ready, so ready never loops on itself.
  assign w_advance  = ~r_rsp_valid | rsp_ready;
  assign req0_ready = w_grant0 & w_advance;
  assign req1_ready = w_grant1 & w_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_op_valid   <= 1'b0;
      r_op_id      <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctrl    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_z      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_c      <= 1'b0;
      r_rsp_v      <= 1'b0;
    end else if (w_advance) begin
      r_rsp_valid  <= r_op_valid;
      r_rsp_id     <= r_op_id;
      r_rsp_err    <= ~is_legal_op(r_op_ctrl);
      r_rsp_result <= w_alu_result;
      r_rsp_z      <= w_alu_z;
      r_rsp_n      <= w_alu_n;
      r_rsp_c      <= w_alu_c;
      r_rsp_v      <= w_alu_v;
      r_op_valid   <= w_grant0 | w_grant1;
      if (w_grant0 | w_grant1) begin
        r_op_id      <= w_grant1;
        r_op_a       <= w_grant1 ? req1_a    : req0_a;
        r_op_b       <= w_grant1 ? req1_b    : req0_b;
        r_op_ctrl    <= w_grant1 ? req1_ctrl : req0_ctrl;
        r_last_grant <= w_grant1;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_err    = r_rsp_err;
  assign rsp_result = r_rsp_result;
  assign rsp_z      = r_rsp_z;
  assign rsp_n      = r_rsp_n;
  assign rsp_c      = r_rsp_c;
  assign rsp_v      = r_rsp_v;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: self-checking bench for alu_share_arb (XLEN=32).
// A cycle-level reference of the two-stage pipeline plus an arithmetic ALU
// model predicts readies and responses every cycle; scenario tasks add
// explicit checks of the documented example values.
module tb_alu_share_arb;

  typedef struct packed {
    logic        err;
    logic [31:0] res;
    logic [3:0]  fl;   // {z, n, c, v}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_z, rsp_n, rsp_c, rsp_v, rsp_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference state
  logic        m_last;
  logic        m_op_v, m_op_id;
  logic [31:0] m_op_a, m_op_b;
  logic [3:0]  m_op_ctrl;
  logic        m_rsp_v, m_rsp_id;
  exp_t        m_rsp;
  logic        e_g0 = 1'b0, e_g1 = 1'b0;

  alu_share_arb #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .rsp_c      (rsp_c),
    .rsp_v      (rsp_v),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          sa, sb, s;
    longint unsigned ua, ub;
    int unsigned     sh;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = b[4:0];
    case (op)
      4'd0: begin
        s = sa + sb;
        e.res = a + b;
        e.fl[1] = (ua + ub) > 64'hFFFF_FFFF;
        e.fl[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s = sa - sb;
        e.res = a - b;
        e.fl[1] = (ua >= ub);
        e.fl[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a << sh;
      4'd5:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  e.res = a ^ b;
      4'd7:  e.res = a >> sh;
      4'd8:  e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'd15: begin s = sa >>> sh; e.res = s[31:0]; end
      default: e.err = 1'b1;
    endcase
    e.fl[3] = (e.res == 32'd0);
    e.fl[2] = e.res[31];
    return e;
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_op_v = 1'b0; m_op_id = 1'b0;
    m_op_a = '0; m_op_b = '0; m_op_ctrl = '0;
    m_rsp_v = 1'b0; m_rsp_id = 1'b0; m_rsp = '0;
    e_g0 = 1'b0; e_g1 = 1'b0;
  endtask

  // Checks one cycle against the reference at the falling edge, then
  // advances the reference across the rising edge.
  task automatic cycle();
    logic adv, g0, g1;
    @(negedge clk);
    adv = !m_rsp_v || rsp_ready;
    g0 = 1'b0; g1 = 1'b0;
    if (adv) begin
      if (req0_valid && req1_valid) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else if (req0_valid) g0 = 1'b1;
      else if (req1_valid) g1 = 1'b1;
    end
    e_g0 = g0; e_g1 = g1;
    n_checks++;
    if (req0_ready !== g0) begin n_errors++; $display("FAIL ready0 got=%b exp=%b t=%0t", req0_ready, g0, $time); end
    n_checks++;
    if (req1_ready !== g1) begin n_errors++; $display("FAIL ready1 got=%b exp=%b t=%0t", req1_ready, g1, $time); end
    n_checks++;
    if (rsp_valid !== m_rsp_v) begin n_errors++; $display("FAIL rsp_valid got=%b exp=%b t=%0t", rsp_valid, m_rsp_v, $time); end
    if (m_rsp_v) begin
      n_checks++;
      if (rsp_id !== m_rsp_id) begin n_errors++; $display("FAIL rsp_id got=%b exp=%b t=%0t", rsp_id, m_rsp_id, $time); end
      n_checks++;
      if (rsp_err !== m_rsp.err) begin n_errors++; $display("FAIL rsp_err got=%b exp=%b t=%0t", rsp_err, m_rsp.err, $time); end
      if (!m_rsp.err) begin
        n_checks++;
        if (rsp_result !== m_rsp.res) begin n_errors++; $display("FAIL rsp_result got=%h exp=%h t=%0t", rsp_result, m_rsp.res, $time); end
        n_checks++;
        if ({rsp_z, rsp_n, rsp_c, rsp_v} !== m_rsp.fl) begin
          n_errors++; $display("FAIL rsp_flags got=%b exp=%b t=%0t", {rsp_z, rsp_n, rsp_c, rsp_v}, m_rsp.fl, $time);
        end
      end
    end
    @(posedge clk);
    if (adv) begin
      m_rsp_v  = m_op_v;
      m_rsp_id = m_op_id;
      m_rsp    = ref_alu(m_op_ctrl, m_op_a, m_op_b);
      m_op_v   = g0 | g1;
      if (g0 | g1) begin
        m_op_id   = g1;
        m_op_a    = g1 ? req1_a : req0_a;
        m_op_b    = g1 ? req1_b : req0_b;
        m_op_ctrl = g1 ? req1_ctrl : req0_ctrl;
        m_last    = g1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_z, rsp_n, rsp_c, rsp_v} !== 7'b0 || rsp_result !== 32'd0) begin
      n_errors++; $display("FAIL reset_state got=%b/%h exp=0/0", {rsp_valid, rsp_id, rsp_err, rsp_z, rsp_n, rsp_c, rsp_v}, rsp_result);
    end
    apply_reset();
    cycle();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_ctrl = 4'h0; req0_a = 32'h5; req0_b = 32'h3;
    cycle();
    req0_valid = 1'b0;
    cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h8 || {rsp_z, rsp_n, rsp_c, rsp_v} !== 4'b0) begin
      n_errors++; $display("FAIL single_add got=%b/%b/%h/%b exp=1/0/00000008/0000", rsp_valid, rsp_id, rsp_result, {rsp_z, rsp_n, rsp_c, rsp_v});
    end
    repeat (2) cycle();
  endtask

  task automatic test_contention();
    logic [31:0] exp_res;
    apply_reset();
    req0_valid = 1'b1; req0_ctrl = 4'h1; req0_a = 32'd5; req0_b = 32'd10;
    req1_valid = 1'b1; req1_ctrl = 4'h8; req1_a = 32'd5; req1_b = 32'h10;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k >= 1) begin
        exp_res = (k % 2 == 1) ? 32'hFFFF_FFFB : 32'h1;
        n_checks++;
        if (rsp_id !== logic'((k - 1) % 2) || rsp_result !== exp_res) begin
          n_errors++; $display("FAIL contention_rsp%0d got=%b/%h exp=%0d/%h", k, rsp_id, rsp_result, (k - 1) % 2, exp_res);
        end
      end
    end
  endtask

  // Continues from a full pipeline with both requesters still valid.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    repeat (2) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_undefined();
    req1_valid = 1'b1; req1_ctrl = 4'b1010; req1_a = $urandom; req1_b = $urandom;
    cycle();
    req1_ctrl = 4'hF; req1_a = 32'h8000_0010; req1_b = 32'd2;
    cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b1) begin
      n_errors++; $display("FAIL undef_err got=%b/%b/%b exp=1/1/1", rsp_valid, rsp_err, rsp_id);
    end
    req1_valid = 1'b0;
    cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_id !== 1'b1 || rsp_result !== 32'hE000_0004) begin
      n_errors++; $display("FAIL sra_after_undef got=%b/%b/%b/%h exp=1/0/1/e0000004", rsp_valid, rsp_err, rsp_id, rsp_result);
    end
    cycle();
  endtask

  task automatic test_mid_reset();
    req0_valid = 1'b1; req0_ctrl = 4'h6; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_ctrl = 4'h2; req1_a = $urandom; req1_b = $urandom;
    repeat (2) cycle();
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_full got=%b exp=1", rsp_valid); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL midrst_async got=%b/%h/%b exp=0/00000000/0", rsp_valid, rsp_result, rsp_err);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_errors++; $display("FAIL midrst_first_grant got=%b%b exp=10", req0_ready, req1_ready);
    end
    repeat (3) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    int unsigned hs;
    hs = 0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_ctrl = 4'($urandom_range(0, 8)); req0_a = $urandom; req0_b = $urandom;
      #1 if (req0_ready === 1'b1) hs++;
      cycle();
    end
    req0_valid = 1'b0;
    n_checks++;
    if (hs !== 4) begin n_errors++; $display("FAIL b2b_handshakes got=%0d exp=4", hs); end
    repeat (3) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || e_g0) begin
        req0_valid = ($urandom_range(0, 9) < 7);
        req0_ctrl = 4'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom;
      end else if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
      if (!req1_valid || e_g1) begin
        req1_valid = ($urandom_range(0, 9) < 7);
        req1_ctrl = 4'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom;
      end else if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_undefined();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
